sw_debounce: RTL

- Upstream conditioning stage for the board switch bank.
- Synchronises raw asynchronous slide-switch inputs into the clock domain, then debounces them per bit.
- Presents clean, stable switch levels to the downstream select/data mux logic, which consumes sw_clean in place of raw switches.
- Also produces one-cycle rise/fall pulses per bit for counter or FSM consumers.

---
 rtl/sw_debounce_bit.sv | 32 +++
 rtl/sw_debounce.sv | 34 +++
 2 files changed

// File: rtl/sw_debounce_bit.sv
// debounce_bit: accepts a new level once the synchronised input has differed from it for DEBOUNCE_CYCLES edges
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic in_sync,
  output logic clean,
  output logic rise,
  output logic fall
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      clean <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (in_sync == clean) cnt <= '0;
      else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        clean <= in_sync;
        cnt <= '0;
        rise <= in_sync;
        fall <= ~in_sync;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchroniser followed by independent per-bit debouncers with edge pulses
module sw_debounce #(
  parameter int WIDTH = 10,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);
  logic [WIDTH-1:0] s1, s2;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw;
      s2 <= s1;
    end
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_bit (
      .clk(clk),
      .reset(reset),
      .in_sync(s2[i]),
      .clean(sw_clean[i]),
      .rise(sw_rise[i]),
      .fall(sw_fall[i])
    );
  end
endmodule
